uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NREQ byte requesters onto one UART transmitter, strobing one write per frame and
// enforcing an inter-frame gap. Define UART_ARB_RR_EN for round-robin; otherwise lowest index wins.
module uart_tx_arbiter #(
  parameter int NREQ          = 2,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 255
) (
  input  logic              Uart_CLK,
  input  logic              Sys_RST,
  input  logic [NREQ-1:0]   Req,
  input  logic [8*NREQ-1:0] Req_Data,
  output logic [NREQ-1:0]   Grant_Ack,
  input  logic              Tx_Busy,
  output logic [7:0]        Tx_Data,
  output logic              Tx_Wrsig,
  output logic              Busy,
  output logic              Timeout_Err
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_STROBE, S_WSTART, S_WDONE, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [7:0]      data_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic            wrsig_nxt, terr_nxt;
  logic [IDXW-1:0] win;
  logic [7:0]      req_bytes [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_bytes
    assign req_bytes[i] = Req_Data[8*i +: 8];
  end

`ifdef UART_ARB_RR_EN
  logic [IDXW-1:0] ptr;

  // Scan backwards so the requester closest to ptr in wrap order is written last and wins.
  always_comb begin
    int idx;
    idx = 0;
    win = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (Req[IDXW'(idx)]) win = IDXW'(idx);
    end
  end

  always_ff @(posedge Uart_CLK or negedge Sys_RST) begin
    if (!Sys_RST)
      ptr <= '0;
    else if (state == S_IDLE && |Req)
      ptr <= (win == IDXW'(NREQ - 1)) ? '0 : win + 1'b1;
  end
`else
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (Req[k]) win = IDXW'(k);
  end
`endif

  always_ff @(posedge Uart_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      Tx_Data     <= '0;
      Grant_Ack   <= '0;
      Tx_Wrsig    <= 1'b0;
      Busy        <= 1'b0;
      Timeout_Err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      Tx_Data     <= data_nxt;
      Grant_Ack   <= ack_nxt;
      Tx_Wrsig    <= wrsig_nxt;
      Busy        <= (state_nxt != S_IDLE);
      Timeout_Err <= terr_nxt;
    end
  end

  // Tx_Data only reloads on a grant, so it stays put for the whole frame.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = Tx_Data;
    ack_nxt   = '0;
    wrsig_nxt = 1'b0;
    terr_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (|Req) begin
          data_nxt     = req_bytes[win];
          ack_nxt[win] = 1'b1;
          state_nxt    = S_STROBE;
        end
      end
      S_STROBE: begin
        wrsig_nxt = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_WSTART;
      end
      S_WSTART: begin
        if (Tx_Busy) begin
          state_nxt = S_WDONE;
        end else if (cnt == 8'(START_TIMEOUT)) begin
          terr_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_WDONE: begin
        if (!Tx_Busy) begin
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        cnt_nxt = cnt + 8'd1;
        if (cnt == 8'(GAP_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
